// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with a 1-cycle latency.
// The output slot (out_valid/out_pc/out_data) and level come straight from flops.
// Optional macro PIPE_STAGE_SKID_EN adds a one-entry skid buffer. This gives a
// capacity of 2, and in_ready then comes from a flop that is set when the skid
// buffer is empty. Without the macro the stage holds one entry and in_ready is
// the combinational term !out_valid || out_ready.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   flush               synchronous kill of held and incoming entries
//   in_valid/in_ready   upstream handshake, in_pc/in_data payload
//   out_valid/out_ready downstream handshake, out_pc/out_data payload
//   level               number of entries held (0..2)
module pipe_stage_reg #(
  parameter int unsigned       PC_W   = 32,
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  logic              out_valid_n;
  logic [PC_W-1:0]   out_pc_n;
  logic [DATA_W-1:0] out_data_n;
  logic [1:0]        level_n;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid, skid_valid_n;
  logic [PC_W-1:0]   skid_pc, skid_pc_n;
  logic [DATA_W-1:0] skid_data, skid_data_n;
  logic              in_ready_n;

  // Next state: the skid entry has priority when refilling the output slot.
  // This keeps entries in order. in_ready is low whenever the skid buffer is
  // full, so an accept never happens while the skid buffer is occupied.
  always_comb begin
    out_valid_n  = out_valid;
    out_pc_n     = out_pc;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_pc_n    = skid_pc;
    skid_data_n  = skid_data;
    if (flush) begin
      out_valid_n  = 1'b0;
      out_pc_n     = '0;
      out_data_n   = BUBBLE;
      skid_valid_n = 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_pc_n     = skid_pc;
        out_data_n   = skid_data;
        skid_valid_n = 1'b0;
      end else if (in_valid && in_ready) begin
        out_valid_n = 1'b1;
        out_pc_n    = in_pc;
        out_data_n  = in_data;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (in_valid && in_ready) begin
      skid_valid_n = 1'b1;
      skid_pc_n    = in_pc;
      skid_data_n  = in_data;
    end
    in_ready_n = !skid_valid_n;
    level_n    = 2'({1'b0, out_valid_n} + {1'b0, skid_valid_n});
  end

  // Skid buffer and registered in_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else begin
      skid_valid <= skid_valid_n;
      skid_pc    <= skid_pc_n;
      skid_data  <= skid_data_n;
      in_ready   <= in_ready_n;
    end
  end
`else
  // Single-entry stage: accept whenever the slot is empty or drains this edge.
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    out_valid_n = out_valid;
    out_pc_n    = out_pc;
    out_data_n  = out_data;
    if (flush) begin
      out_valid_n = 1'b0;
      out_pc_n    = '0;
      out_data_n  = BUBBLE;
    end else if (in_ready) begin
      out_valid_n = in_valid;
      if (in_valid) begin
        out_pc_n   = in_pc;
        out_data_n = in_data;
      end
    end
    level_n = {1'b0, out_valid_n};
  end
`endif

  // Output slot and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_data  <= BUBBLE;
      level     <= 2'd0;
    end else begin
      out_valid <= out_valid_n;
      out_pc    <= out_pc_n;
      out_data  <= out_data_n;
      level     <= level_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg. It applies a
// directed vector table, a reset asserted between clock edges, and a random
// handshake stream. A queue scoreboard tracks the entries that the stage holds.
module tb_pipe_stage_reg;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        level;

  pipe_stage_reg #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_data(out_data), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] pc;
    logic        e_valid;
    logic [31:0] e_pc, e_data;
    logic [1:0]  e_level;
    logic        e_rdy;
  } vec_t;

  ent_t sb[$];
  vec_t vec[9];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] dat_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                              input logic [31:0] pc, input logic ev,
                              input logic [31:0] epc, input logic [31:0] edat,
                              input logic [1:0] elvl, input logic erdy);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc; v.e_valid = ev;
    v.e_pc = epc; v.e_data = edat; v.e_level = elvl; v.e_rdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample the handshake at negedge, check after the edge.
  task automatic cycle(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] pc);
    logic acc, del;
    ent_t e;
    in_valid = iv; out_ready = ordy; flush = fl; in_pc = pc; in_data = dat_of(pc);
    @(negedge clk);
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    if (del) begin
      if (sb.size() == 0) begin
        chk("sb_spurious_output", out_pc, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("sb_out_pc", out_pc, e.pc);
        chk("sb_out_data", out_data, e.data);
      end
    end
    if (acc) begin
      e.pc = in_pc; e.data = in_data;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    chk("sb_level", 32'(level), 32'(sb.size()));
    chk("sb_out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("level_cap", 32'(int'(level) <= int'(CAP)), 32'd1);
  endtask

  initial begin
    // Directed vectors: stream, back-pressure, drain, then flush with a live offer.
    vec[0] = mk(1, 1, 0, 32'h00, 1, 32'h00, dat_of(32'h00), 2'd1, 1);
    vec[1] = mk(1, 1, 0, 32'h04, 1, 32'h04, dat_of(32'h04), 2'd1, 1);
    vec[2] = mk(1, 1, 0, 32'h08, 1, 32'h08, dat_of(32'h08), 2'd1, 1);
    vec[3] = mk(1, 1, 0, 32'h0C, 1, 32'h0C, dat_of(32'h0C), 2'd1, 1);
`ifdef PIPE_STAGE_SKID_EN
    vec[4] = mk(1, 0, 0, 32'h10, 1, 32'h0C, dat_of(32'h0C), 2'd2, 0);
    vec[5] = mk(0, 1, 0, 32'h00, 1, 32'h10, dat_of(32'h10), 2'd1, 1);
    vec[6] = mk(0, 0, 0, 32'h00, 1, 32'h10, dat_of(32'h10), 2'd1, 1);
`else
    vec[4] = mk(1, 0, 0, 32'h10, 1, 32'h0C, dat_of(32'h0C), 2'd1, 0);
    vec[5] = mk(0, 1, 0, 32'h00, 0, 32'h0C, dat_of(32'h0C), 2'd0, 1);
    vec[6] = mk(0, 0, 0, 32'h00, 0, 32'h0C, dat_of(32'h0C), 2'd0, 1);
`endif
    vec[7] = mk(1, 1, 1, 32'h20, 0, 32'h00, NOP, 2'd0, 1);
    vec[8] = mk(0, 1, 0, 32'h00, 0, 32'h00, NOP, 2'd0, 1);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_pc = 32'h99; in_data = 32'h99;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_data", out_data, NOP);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      cycle(vec[i].iv, vec[i].ordy, vec[i].fl, vec[i].pc);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vec[i].e_valid));
      chk($sformatf("v%0d_out_pc", i), out_pc, vec[i].e_pc);
      chk($sformatf("v%0d_out_data", i), out_data, vec[i].e_data);
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vec[i].e_level));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].e_rdy));
    end

    // Fill the stage with back-pressure, then assert reset between edges.
    cycle(1, 1, 0, 32'h30);
    cycle(1, 0, 0, 32'h34);
    chk("pre_rst_level", 32'(level), 32'(CAP));
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_out_data", out_data, NOP);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1, 1, 0, 32'h40);
    chk("post_rst_out_pc", out_pc, 32'h40);
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    cycle(0, 1, 0, 32'h0);

    // Random handshakes with occasional flush
    for (int n = 0; n < 10000; n++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 63) == 0), 32'(n * 4 + 32'h100));
    end
    for (int n = 0; n < 4; n++) cycle(0, 1, 0, 32'h0);
    chk("drain_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
